trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Multicycle trap-entry and trap-return sequencer for the machine-mode CSR file. It takes pending interrupt and exception indications plus the encoded trap cause from the interrupt controller. At an instruction boundary it steps the shared single-port CSR write bus through mepc, mcause, mtval and mstatus updates, then redirects the PC to the trap handler. It also sequences `mret`: it restores mstatus and redirects to mepc. While a sequence runs it stalls the core.

## Interface
Parameters:
- `RESET_VECTOR`, `32'h0000_0000`: value driven on `pc_target` while idle and after reset.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `inst_boundary`  in  1  core is between instructions and can accept a trap or mret.
- `interrupt_pending`  in  1  enabled interrupt pending.
- `exception_pending`  in  1  synchronous exception raised by the current instruction.
- `trap_cause`  in  32  bit31 = interrupt, bits[4:0] = code.
- `pc_current`  in  32  PC of the current (faulting) instruction.
- `pc_next`  in  32  PC of the next instruction to execute.
- `trap_value`  in  32  mtval payload: bad address or instruction bits.
- `mret_req`  in  1  current instruction is `mret`.
- `mtvec`  in  32  current mtvec CSR.
- `mepc`  in  32  current mepc CSR.
- `mstatus`  in  32  current mstatus CSR.
- `csr_we`  out  1  CSR write strobe.
- `csr_addr`  out  12  CSR write address.
- `csr_wdata`  out  32  CSR write data.
- `pc_load`  out  1  one-cycle PC redirect strobe.
- `pc_target`  out  32  redirect address.
- `busy`  out  1  sequence in progress; core stalls.
- `trap_taken`  out  1  one-cycle pulse, same cycle as trap `pc_load`.
- `mret_done`  out  1  one-cycle pulse, same cycle as mret `pc_load`.

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP.

Acceptance in IDLE, only when `inst_boundary` = 1:
- If `interrupt_pending` or `exception_pending`, go to T_MEPC.
- Otherwise, if `mret_req`, go to R_MSTATUS.
- A trap always wins over a simultaneous `mret_req`, and the mret is dropped.
- Requests are ignored in every state except IDLE.

Capture at acceptance into internal registers (later input changes are ignored):
- cause, from `trap_cause`.
- epc: `pc_next` when trap_cause[31] = 1, else `pc_current`.
- tval: 0 for interrupts, else `trap_value`.
- `mtvec` and `mepc`.

Trap path:
- T_MEPC writes 0x341 ← epc.
- T_MCAUSE writes 0x342 ← cause.
- T_MTVAL writes 0x343 ← tval.
- T_MSTATUS writes 0x300 ← mstatus with MPIE(bit7) = MIE(bit3), MIE = 0, MPP[12:11] = 2'b11; all other bits are unchanged. The live `mstatus` input is sampled in this state.
- T_JUMP drives `pc_load`, `trap_taken` and `pc_target` = handler address, then returns to IDLE.

Return path:
- R_MSTATUS writes 0x300 ← mstatus with MIE = MPIE, MPIE = 1, MPP = 2'b11.
- R_JUMP drives `pc_load`, `mret_done` and `pc_target` = {captured mepc[31:2], 2'b00}, then returns to IDLE.

Outputs:
- `busy` = (state ≠ IDLE), combinational.
- `csr_we`/`csr_addr`/`csr_wdata` are registered-state decodes. They are 0 in any state that does not write.
- `pc_target` = `RESET_VECTOR` in IDLE.

Arithmetic:
- Handler base = {mtvec[31:2], 2'b00}.
- The vector offset is cause[4:0] << 2, zero-extended to 32 bits.
- The sum wraps modulo 2^32.

## Timing
- Trap: acceptance edge is cycle 0.
  - CSR writes in cycles 1–4, one per cycle, in the order mepc, mcause, mtval, mstatus.
  - `pc_load` in cycle 5.
  - IDLE in cycle 6, when a new request can be accepted.
- Mret: mstatus write in cycle 1, `pc_load` in cycle 2, IDLE in cycle 3.
- Back-to-back: a request present in the first IDLE cycle after a sequence is accepted at that edge.
- Reset, at assertion, asynchronously:
  - state goes to IDLE and captured registers are cleared;
  - `csr_we`, `pc_load`, `busy`, `trap_taken`, `mret_done` = 0; `csr_addr` = 0; `csr_wdata` = 0; `pc_target` = `RESET_VECTOR`.
  - A sequence interrupted by reset is abandoned, with no further writes after release.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - Vectored mode (mtvec[1:0] = 2'b01) with an interrupt gives target = base + offset.
  - Exceptions, and mtvec[1:0] of 2'b00 or 2'b1x, give target = base.
- Undefined: the target is always base, and mtvec[1:0] is ignored.

## Test plan
- Exception: mtvec = 0x100, pc_current = 0x80, cause = 2, trap_value = 0x0000_0013, boundary. Required response: writes 0x341 = 0x80, 0x342 = 2, 0x343 = 0x13, then 0x300 with MIE cleared and MPIE = old MIE; `pc_load` with target 0x100 in cycle 5; `trap_taken` pulses.
- Timer interrupt: mtvec = 0x201, cause = 0x8000_0007, pc_next = 0x44. Required response: mepc = 0x44, mtval = 0; target 0x21C with `TRAP_VECTORED_EN`, 0x200 without.
- Mret: mepc = 0x44, mstatus = 0x80 (MPIE = 1, MIE = 0). Required response: write 0x300 = 0x1888; `pc_load` to 0x44 in cycle 2; `mret_done` pulses.
- Simultaneous `exception_pending` and `mret_req`. Required response: the trap path is taken, no mret writes occur, and `mret_done` stays 0.
- Requests during busy: `interrupt_pending` held high through the sequence. Required response: exactly one sequence, then re-acceptance in the first IDLE cycle.
- Reset asserted in T_MCAUSE. Required response: outputs go to reset values immediately, no mtval or mstatus writes follow, and the block returns to IDLE.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry / mret sequencer on the shared CSR write bus
// Ports: clk, rst (async, active-high); request side inst_boundary, interrupt_pending,
//   exception_pending, mret_req, trap_cause, pc_current, pc_next, trap_value, mtvec, mepc, mstatus;
//   CSR bus csr_we/csr_addr/csr_wdata; redirect pc_load/pc_target; busy, trap_taken, mret_done.
// Build option TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_boundary,
  input  logic        interrupt_pending,
  input  logic        exception_pending,
  input  logic [31:0] trap_cause,
  input  logic [31:0] pc_current,
  input  logic [31:0] pc_next,
  input  logic [31:0] trap_value,
  input  logic        mret_req,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] mstatus,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        busy,
  output logic        trap_taken,
  output logic        mret_done
);
  typedef enum logic [2:0] {IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, T_JUMP, R_MSTATUS, R_JUMP} state_t;
  state_t state_q, state_d;
  logic [31:0] cause_q, cause_d, epc_q, epc_d, tval_q, tval_d, tgt_q, tgt_d;
  logic trap_acc, mret_acc, is_irq;
  logic [31:0] base, handler;
  logic unused;
  assign unused = &{1'b0, mepc[1:0], mtvec[1:0]};
  always_comb begin
    is_irq = trap_cause[31];
    trap_acc = state_q == IDLE && inst_boundary && (interrupt_pending || exception_pending);
    mret_acc = state_q == IDLE && inst_boundary && !trap_acc && mret_req;
    base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    handler = (is_irq && mtvec[1:0] == 2'b01) ? base + {25'b0, trap_cause[4:0], 2'b00} : base;
`else
    handler = base;
`endif
    state_d = trap_acc ? T_MEPC :
              mret_acc ? R_MSTATUS :
              state_q == T_MEPC ? T_MCAUSE :
              state_q == T_MCAUSE ? T_MTVAL :
              state_q == T_MTVAL ? T_MSTATUS :
              state_q == T_MSTATUS ? T_JUMP :
              state_q == R_MSTATUS ? R_JUMP : IDLE;
    cause_d = trap_acc ? trap_cause : cause_q;
    epc_d = trap_acc ? (is_irq ? pc_next : pc_current) : epc_q;
    tval_d = trap_acc ? (is_irq ? 32'h0 : trap_value) : tval_q;
    // the redirect address is resolved at acceptance so later mtvec/mepc changes cannot leak in
    tgt_d = trap_acc ? handler : mret_acc ? {mepc[31:2], 2'b00} : tgt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
      tgt_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q <= epc_d;
      tval_q <= tval_d;
      tgt_q <= tgt_d;
    end
  end
  always_comb begin
    busy = state_q != IDLE;
    csr_we = state_q inside {T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, R_MSTATUS};
    csr_addr = state_q == T_MEPC ? 12'h341 :
               state_q == T_MCAUSE ? 12'h342 :
               state_q == T_MTVAL ? 12'h343 :
               state_q inside {T_MSTATUS, R_MSTATUS} ? 12'h300 : 12'h000;
    // trap entry: MPIE <= MIE, MIE <= 0; mret: MIE <= MPIE, MPIE <= 1; both force MPP to M-mode
    csr_wdata = state_q == T_MEPC ? epc_q :
                state_q == T_MCAUSE ? cause_q :
                state_q == T_MTVAL ? tval_q :
                state_q == T_MSTATUS ? {mstatus[31:13], 2'b11, mstatus[10:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]} :
                state_q == R_MSTATUS ? {mstatus[31:13], 2'b11, mstatus[10:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]} : 32'h0;
    pc_load = state_q inside {T_JUMP, R_JUMP};
    trap_taken = state_q == T_JUMP;
    mret_done = state_q == R_JUMP;
    pc_target = pc_load ? tgt_q : RESET_VECTOR;
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench for trap_sequencer with a queue-based reference model
module tb_trap_sequencer;
  localparam logic [31:0] RV = 32'h0000_1000;
  logic clk = 0, rst = 1;
  logic inst_boundary = 0, interrupt_pending = 0, exception_pending = 0, mret_req = 0;
  logic [31:0] trap_cause = 0, pc_current = 0, pc_next = 0, trap_value = 0, mtvec = 0, mepc = 0, mstatus = 0;
  logic csr_we, pc_load, busy, trap_taken, mret_done;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, pc_target;

  trap_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .inst_boundary(inst_boundary), .interrupt_pending(interrupt_pending),
    .exception_pending(exception_pending), .trap_cause(trap_cause), .pc_current(pc_current),
    .pc_next(pc_next), .trap_value(trap_value), .mret_req(mret_req), .mtvec(mtvec), .mepc(mepc),
    .mstatus(mstatus), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .pc_load(pc_load), .pc_target(pc_target), .busy(busy), .trap_taken(trap_taken), .mret_done(mret_done));

  always #5 clk = ~clk;

  typedef struct {int c; logic [11:0] a; logic [31:0] d;} wr_t;
  typedef struct {int c; logic [31:0] t; logic trap;} jp_t;
  wr_t wq[$];
  jp_t jq[$];
  int total = 0, bad = 0, cyc = 0, rem = 0, n_trap = 0, n_mret = 0;
  logic [31:0] last_target = 0, last_ms = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // reference model: each accepted request becomes a list of timed bus writes and one redirect
  logic m_irq;
  logic [31:0] m_ms, m_tgt;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      rem = 0;
      wq.delete();
      jq.delete();
    end else if (rem > 0) rem--;
    else if (inst_boundary && (interrupt_pending || exception_pending)) begin
      m_irq = trap_cause[31];
      m_ms = mstatus;
      m_ms[7] = mstatus[3];
      m_ms[3] = 1'b0;
      m_ms[12:11] = 2'b11;
      m_tgt = mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (m_irq && mtvec[1:0] == 2'b01) m_tgt = m_tgt + 32'(trap_cause[4:0]) * 4;
`endif
      wq.push_back('{cyc, 12'h341, m_irq ? pc_next : pc_current});
      wq.push_back('{cyc + 1, 12'h342, trap_cause});
      wq.push_back('{cyc + 2, 12'h343, m_irq ? 32'h0 : trap_value});
      wq.push_back('{cyc + 3, 12'h300, m_ms});
      jq.push_back('{cyc + 4, m_tgt, 1'b1});
      rem = 5;
    end else if (inst_boundary && mret_req) begin
      m_ms = mstatus;
      m_ms[3] = mstatus[7];
      m_ms[7] = 1'b1;
      m_ms[12:11] = 2'b11;
      wq.push_back('{cyc, 12'h300, m_ms});
      jq.push_back('{cyc + 1, mepc & ~32'h3, 1'b0});
      rem = 2;
    end
  end

  wr_t w;
  jp_t j;
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", {31'b0, busy}, {31'b0, rem != 0});
      if (csr_we) begin
        if (wq.size() == 0) chk("spurious_write", {20'b0, csr_addr}, 32'h0);
        else begin
          w = wq.pop_front();
          chk("wr_cycle", cyc, w.c);
          chk("wr_addr", {20'b0, csr_addr}, {20'b0, w.a});
          chk("wr_data", csr_wdata, w.d);
          if (csr_addr == 12'h300) last_ms = csr_wdata;
        end
      end else begin
        chk("addr_idle", {20'b0, csr_addr}, 32'h0);
        chk("wdata_idle", csr_wdata, 32'h0);
        if (wq.size() != 0 && wq[0].c <= cyc) begin
          chk("missing_write", {20'b0, csr_addr}, {20'b0, wq[0].a});
          void'(wq.pop_front());
        end
      end
      if (pc_load) begin
        if (jq.size() == 0) chk("spurious_jump", pc_target, 32'h0);
        else begin
          j = jq.pop_front();
          chk("jump_cycle", cyc, j.c);
          chk("jump_target", pc_target, j.t);
          chk("trap_taken", {31'b0, trap_taken}, {31'b0, j.trap});
          chk("mret_done", {31'b0, mret_done}, {31'b0, !j.trap});
          last_target = pc_target;
          if (trap_taken) n_trap++;
          if (mret_done) n_mret++;
        end
      end else begin
        chk("taken_idle", {31'b0, trap_taken}, 32'h0);
        chk("mret_idle", {31'b0, mret_done}, 32'h0);
        if (!busy) chk("target_idle", pc_target, RV);
        if (jq.size() != 0 && jq[0].c <= cyc) begin
          chk("missing_jump", pc_target, jq[0].t);
          void'(jq.pop_front());
        end
      end
    end
  end

  task automatic chk_reset();
    chk("rst_we", {31'b0, csr_we}, 32'h0);
    chk("rst_addr", {20'b0, csr_addr}, 32'h0);
    chk("rst_wdata", csr_wdata, 32'h0);
    chk("rst_pc_load", {31'b0, pc_load}, 32'h0);
    chk("rst_target", pc_target, RV);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_taken", {31'b0, trap_taken}, 32'h0);
    chk("rst_mret", {31'b0, mret_done}, 32'h0);
  endtask

  task automatic scramble();
    trap_cause = $urandom; pc_current = $urandom; pc_next = $urandom;
    trap_value = $urandom; mtvec = $urandom; mepc = $urandom;
  endtask

  task automatic req(input logic irq, input logic exc, input logic mr, input logic [31:0] cause,
                     input logic [31:0] pcc, input logic [31:0] pcn, input logic [31:0] tv,
                     input logic [31:0] tvec, input logic [31:0] ep, input logic [31:0] ms);
    inst_boundary = 1; interrupt_pending = irq; exception_pending = exc; mret_req = mr;
    trap_cause = cause; pc_current = pcc; pc_next = pcn; trap_value = tv; mtvec = tvec; mepc = ep; mstatus = ms;
    @(posedge clk); #1;
    inst_boundary = 0; interrupt_pending = 0; exception_pending = 0; mret_req = 0;
    scramble();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && rem != 0; i++) @(posedge clk);
    #1;
    if (rem != 0) chk("idle_timeout", rem, 0);
  endtask

  int t0, m0;
  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset();
    rst = 0;
    @(posedge clk); #1;
    req(0, 1, 0, 32'h2, 32'h80, 32'h84, 32'h13, 32'h100, 32'h0, 32'h8);
    wait_idle();
    chk("exc_target", last_target, 32'h100);
    chk("exc_mstatus", last_ms, 32'h1880);
    req(1, 0, 0, 32'h8000_0007, 32'h40, 32'h44, 32'hdead, 32'h201, 32'h0, 32'h8);
    wait_idle();
`ifdef TRAP_VECTORED_EN
    chk("timer_target", last_target, 32'h21c);
`else
    chk("timer_target", last_target, 32'h200);
`endif
    req(0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h44, 32'h80);
    wait_idle();
    chk("mret_target", last_target, 32'h44);
    chk("mret_mstatus", last_ms, 32'h1888);
    t0 = n_trap; m0 = n_mret;
    req(0, 1, 1, 32'h5, 32'h300, 32'h304, 32'h55, 32'h400, 32'h88, 32'h88);
    wait_idle();
    chk("simul_trap", n_trap - t0, 1);
    chk("simul_no_mret", n_mret - m0, 0);
    t0 = n_trap;
    inst_boundary = 1; interrupt_pending = 1; trap_cause = 32'h8000_0003;
    pc_next = 32'h600; mtvec = 32'h801; mstatus = 32'h0;
    repeat (13) @(posedge clk);
    #1 inst_boundary = 0; interrupt_pending = 0;
    wait_idle();
    chk("held_irq_count", n_trap - t0, 3);
    req(0, 1, 0, 32'h4, 32'h900, 32'h904, 32'h77, 32'hA00, 32'h0, 32'h8);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1;
    wq.delete(); jq.delete(); rem = 0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      inst_boundary = $urandom_range(2) != 0;
      interrupt_pending = $urandom_range(5) == 0;
      exception_pending = $urandom_range(5) == 0;
      mret_req = $urandom_range(3) == 0;
      scramble();
      if (rem == 0) mstatus = $urandom;
      @(posedge clk); #1;
    end
    inst_boundary = 0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("wq_drained", wq.size(), 0);
    chk("jq_drained", jq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
